// File: rtl/uart_rx_dev_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_dev_if
// Description : Device-port bus bundle for the UART receiver. It carries the
//               request, address, write enable, byte enables and write data
//               from the core, and the registered response (valid + read
//               data) back to it.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_dev_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  // The core issues requests and consumes responses.
  modport master (
    output req,
    output addr,
    output we,
    output be,
    output wdata,
    input  rvalid,
    input  rdata
  );

  // The device accepts requests and produces responses.
  modport slave (
    input  req,
    input  addr,
    input  we,
    input  be,
    input  wdata,
    output rvalid,
    output rdata
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_dev.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_dev
// Description : Bus-attached 8N1 UART receiver. The serial line is
//               synchronised, each character is deframed by a bit-timing
//               FSM and good bytes are buffered in a FIFO. The core pops the
//               FIFO through RXDATA, watches STATUS and enables a level
//               interrupt through CTRL.
//               Register map (offset = addr[3:2]):
//                 0x0 RXDATA  RO  {24'b0, byte} or 32'h8000_0000 when empty
//                 0x4 STATUS  RO/W1C  [0] empty [1] full [2] overrun
//                                     [3] frame_err [12:8] level
//                 0x8 CTRL    RW  [0] irq_en, [1] flush (self-clearing)
//                 0xC reserved, reads 0
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_dev #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned RxFifoDepth    = 16
) (
  input  logic           clk_sys_i,
  input  logic           rst_sys_ni,
  uart_rx_dev_if.slave   device,
  input  logic           uart_rx_i,
  output logic           uart_rx_irq_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned c_clks_per_bit = ClockFrequency / BaudRate;
  // Counter only ever holds values up to c_clks_per_bit-1.
  localparam int unsigned c_cnt_w        = $clog2(c_clks_per_bit);
  localparam int unsigned c_ptr_w        = $clog2(RxFifoDepth);

  localparam logic [c_cnt_w-1:0] c_cnt_bit  = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_clks_per_bit / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w:0]   c_ptr_one  = (c_ptr_w + 1)'(1);

  localparam logic [1:0] c_off_rxdata = 2'd0;
  localparam logic [1:0] c_off_status = 2'd1;
  localparam logic [1:0] c_off_ctrl   = 2'd2;

  // --------------------------------------------------------------------------
  // Receive FSM state
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

  state_e               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_rx_push;   // one-cycle pulse: r_shift holds a good byte
  logic                 r_rx_ferr;   // one-cycle pulse: stop bit was low

  logic [1:0]           r_rx_sync;
  logic                 w_rx_s;

  // --------------------------------------------------------------------------
  // FIFO, flags and bus state
  // --------------------------------------------------------------------------
  logic [7:0]           r_mem [RxFifoDepth];
  logic [c_ptr_w:0]     r_wptr;
  logic [c_ptr_w:0]     r_rptr;
  logic                 r_overrun;
  logic                 r_frame_err;
  logic                 r_irq_en;
  logic                 r_irq;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;

  logic [c_ptr_w:0]     w_level;
  logic [31:0]          w_level32;
  logic                 w_empty;
  logic                 w_full;
  logic [1:0]           w_off;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_push_ok;
  logic                 w_ovr_set;
  logic                 w_status_wr;
  logic                 w_ctrl_wr;
  logic [31:0]          w_status;
  logic [31:0]          w_rd_mux;
  logic                 w_unused_bits;

  // --------------------------------------------------------------------------
  // Input synchroniser; the raw line is never used anywhere else.
  // --------------------------------------------------------------------------
  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_rx_sync <= 2'b11;
    end else begin
      r_rx_sync <= {r_rx_sync[0], uart_rx_i};
    end
  end

  assign w_rx_s = r_rx_sync[1];

  // --------------------------------------------------------------------------
  // Deframing FSM: finds the start bit, samples each bit at its centre and
  // checks the stop bit. The push/error pulses are registered, so the FIFO
  // sees a completed byte one cycle after the stop-bit sample.
  // --------------------------------------------------------------------------
  // Bit-timing state machine with registered push / frame-error pulses.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_rx_push <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      r_rx_push <= 1'b0;
      r_rx_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            // Half a bit lands the next sample in the middle of the start bit.
            r_cnt   <= c_cnt_half;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == '0) begin
            if (!w_rx_s) begin
              r_cnt     <= c_cnt_bit;
              r_bit_idx <= '0;
              r_state   <= ST_DATA;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        ST_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_cnt   <= c_cnt_bit;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        ST_STOP: begin
          if (r_cnt == '0) begin
            if (w_rx_s) begin
              r_rx_push <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_rx_ferr <= 1'b1;
              r_state   <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        ST_WAIT_IDLE: begin
          // Holding here until the line recovers keeps a break from being
          // counted as a stream of framing errors.
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus decode and FIFO control
  // --------------------------------------------------------------------------
  assign w_off       = device.addr[3:2];
  assign w_rd        = device.req & ~device.we;
  assign w_wr        = device.req &  device.we;
  assign w_level     = r_wptr - r_rptr;
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                       (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
  assign w_pop       = w_rd & (w_off == c_off_rxdata) & ~w_empty;
  assign w_flush     = w_wr & (w_off == c_off_ctrl) & device.wdata[1];
  assign w_status_wr = w_wr & (w_off == c_off_status);
  assign w_ctrl_wr   = w_wr & (w_off == c_off_ctrl);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  // A flush wins over a coincident push.
  assign w_push_ok   = r_rx_push & (~w_full | w_pop) & ~w_flush;
  assign w_ovr_set   = r_rx_push & w_full & ~w_pop & ~w_flush;

  // Byte enables and the undecoded address/data bits have no function here.
  assign w_unused_bits = ^{device.be, device.addr[31:4], device.addr[1:0],
                           device.wdata[31:4]};

  // FIFO storage write port.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int i = 0; i < RxFifoDepth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wptr[c_ptr_w-1:0]] <= r_shift;
    end
  end

  // FIFO read/write pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
    end
  end

  // Sticky error flags and interrupt enable; a new set event beats a W1C.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq_en    <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (w_status_wr && device.wdata[2]) begin
        r_overrun <= 1'b0;
      end
      if (r_rx_ferr) begin
        r_frame_err <= 1'b1;
      end else if (w_status_wr && device.wdata[3]) begin
        r_frame_err <= 1'b0;
      end
      if (w_ctrl_wr) begin
        r_irq_en <= device.wdata[0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
  assign w_level32 = 32'(w_level);
  assign w_status  = {19'b0, w_level32[4:0], 4'b0,
                      r_frame_err, r_overrun, w_full, w_empty};

  // Register read multiplexer, evaluated on the pre-access state.
  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      c_off_rxdata: w_rd_mux = w_empty ? 32'h8000_0000
                                       : {24'b0, r_mem[r_rptr[c_ptr_w-1:0]]};
      c_off_status: w_rd_mux = w_status;
      c_off_ctrl:   w_rd_mux = {31'b0, r_irq_en};
      default:      w_rd_mux = '0;
    endcase
  end

  // Single-cycle response: every request is answered on the next cycle.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= device.req;
      r_rdata  <= w_rd ? w_rd_mux : 32'h0;
    end
  end

  // Level interrupt from the current enable and FIFO occupancy.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & ~w_empty;
    end
  end

  assign device.rvalid = r_rvalid;
  assign device.rdata  = r_rdata;
  assign uart_rx_irq_o = r_irq;

endmodule
`default_nettype wire
